// File: rtl/memctrl_host_master.sv
// Host-side initiator: turns read/write burst requests into memory pin beats and returns read data.
// Latency: read data appears RD_LAT+1 cycles after issue. RSP_READY low stalls the FSM in RD_HOLD.
module memctrl_host_master #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [15:0] REQ_ADDR,
  input  logic [3:0]  REQ_LEN,
  input  logic        WD_VALID,
  output logic        WD_READY,
  input  logic [7:0]  WD_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_LAST,
  output logic        BUSY,
  output logic [15:0] ADDR,
  output logic        CE,
  output logic        CSB,
  output logic        WEB,
  output logic        OEB,
  output logic [7:0]  IDATA,
  input  logic [7:0]  ODATA
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_GAP
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP);

  state_t      state;
  logic [15:0] cur_addr;
  logic [3:0]  len_q;
  logic        write_q;
  logic [3:0]  beat;
  logic [2:0]  cnt;

  assign WD_READY = (state == ST_WR_WAIT);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      cur_addr  <= 16'h0000;
      len_q     <= 4'h0;
      write_q   <= 1'b0;
      beat      <= 4'h0;
      cnt       <= 3'd0;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
      RSP_LAST  <= 1'b0;
      BUSY      <= 1'b0;
      ADDR      <= 16'h0000;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      IDATA     <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            cur_addr  <= REQ_ADDR;
            len_q     <= REQ_LEN;
            write_q   <= REQ_WRITE;
            beat      <= 4'h0;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b1;
            if (REQ_WRITE) begin
              state <= ST_WR_WAIT;
            end else begin
              // Pins are registered, so the read issue is set up on the accept edge.
              state <= ST_RD_ISSUE;
              CE    <= 1'b1;
              CSB   <= 1'b0;
              WEB   <= 1'b1;
              OEB   <= 1'b0;
              ADDR  <= REQ_ADDR;
            end
          end else begin
            REQ_READY <= 1'b1;
          end
        end

        ST_WR_WAIT: begin
          if (WD_VALID) begin
            state <= ST_WR_ISSUE;
            CE    <= 1'b1;
            CSB   <= 1'b0;
            WEB   <= 1'b0;
            OEB   <= 1'b1;
            ADDR  <= cur_addr;
            IDATA <= WD_DATA;
          end
        end

        ST_WR_ISSUE: begin
          state <= ST_GAP;
          cnt   <= 3'd0;
          CE    <= 1'b0;
          CSB   <= 1'b1;
          WEB   <= 1'b1;
          OEB   <= 1'b1;
        end

        ST_RD_ISSUE: begin
          // CSB, OEB and ADDR stay asserted through the wait so the memory keeps driving.
          state <= ST_RD_WAIT;
          cnt   <= 3'd0;
          CE    <= 1'b0;
        end

        ST_RD_WAIT: begin
          if (cnt == LAT_LAST) begin
            state     <= ST_RD_HOLD;
            cnt       <= 3'd0;
            RSP_DATA  <= ODATA;
            RSP_VALID <= 1'b1;
            RSP_LAST  <= (beat == len_q);
            CSB       <= 1'b1;
            OEB       <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        ST_RD_HOLD: begin
          if (RSP_READY) begin
            state     <= ST_GAP;
            cnt       <= 3'd0;
            RSP_VALID <= 1'b0;
            RSP_LAST  <= 1'b0;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 3'd0;
            if (beat < len_q) begin
              beat     <= beat + 4'd1;
              cur_addr <= cur_addr + 16'd1;
              if (write_q) begin
                state <= ST_WR_WAIT;
              end else begin
                state <= ST_RD_ISSUE;
                CE    <= 1'b1;
                CSB   <= 1'b0;
                WEB   <= 1'b1;
                OEB   <= 1'b0;
                ADDR  <= cur_addr + 16'd1;
              end
            end else begin
              state     <= ST_IDLE;
              REQ_READY <= 1'b1;
              BUSY      <= 1'b0;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memctrl_host_master.sv
// Bench for memctrl_host_master: per-cycle vector table for reset and writes, directed read sequences.
// Memory model returns ADDR[7:0]^0x5A exactly RD_LAT cycles after a read issue, 0xEE otherwise.
module tb_memctrl_host_master;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [15:0] REQ_ADDR;
  logic [3:0]  REQ_LEN;
  logic        WD_VALID;
  logic        WD_READY;
  logic [7:0]  WD_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [7:0]  RSP_DATA;
  logic        RSP_LAST;
  logic        BUSY;
  logic [15:0] ADDR;
  logic        CE;
  logic        CSB;
  logic        WEB;
  logic        OEB;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;

  memctrl_host_master #(.RD_LAT(2), .GAP(1)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_LAST(RSP_LAST),
    .BUSY(BUSY), .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
    .IDATA(IDATA), .ODATA(ODATA)
  );

  always #5 CLK = ~CLK;

  // Two-stage memory pipeline: issue seen at end of cycle N gives data during cycle N+2.
  logic [7:0] mem_r1, mem_r2;
  always @(posedge CLK) begin
    mem_r1 <= (CE && !CSB && WEB && !OEB) ? (ADDR[7:0] ^ 8'h5A) : 8'hEE;
    mem_r2 <= mem_r1;
  end
  assign ODATA = mem_r2;

  logic [15:0] iss_q[$];
  logic [23:0] wr_q[$];
  always @(negedge CLK) begin
    if (RSTN && CE && !CSB && WEB) iss_q.push_back(ADDR);
    if (RSTN && CE && !CSB && !WEB) wr_q.push_back({ADDR, IDATA});
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rstn, rv, rw;
    logic [15:0] ra;
    logic [3:0]  rl;
    logic        wv;
    logic [7:0]  wd;
    logic        er, ewr, eb;
    logic [3:0]  epins;   // {CE, CSB, WEB, OEB}
    logic [15:0] ea;
    logic [7:0]  ei;
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] P_IDLE = 4'b0111;
  localparam logic [3:0] P_WR   = 4'b1001;

  task automatic add(input logic rstn, input logic rv, input logic rw, input logic [15:0] ra,
                     input logic [3:0] rl, input logic wv, input logic [7:0] wd,
                     input logic er, input logic ewr, input logic eb, input logic [3:0] epins,
                     input logic [15:0] ea, input logic [7:0] ei);
    vec_t v;
    v.rstn = rstn; v.rv = rv; v.rw = rw; v.ra = ra; v.rl = rl; v.wv = wv; v.wd = wd;
    v.er = er; v.ewr = ewr; v.eb = eb; v.epins = epins; v.ea = ea; v.ei = ei;
    vq.push_back(v);
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (!RSP_VALID && k < 50);
    if (!RSP_VALID) check("rsp_timeout", 64'(RSP_VALID), 64'd1);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (!REQ_READY && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    check("idle_reached", 64'(REQ_READY), 64'd1);
  endtask

  // Caller guarantees REQ_READY=1, so the request is accepted on the next edge.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [3:0] l);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_LEN = l;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("req_accept_drop_ready", {62'd0, REQ_READY, BUSY}, 64'b01);
  endtask

  initial begin
    int k;
    logic [7:0]  exp_d[4];
    logic [15:0] a0, a1;
    logic [23:0] w0;
    int stray;

    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = 16'h0; REQ_LEN = 4'h0;
    WD_VALID = 1'b0; WD_DATA = 8'h0; RSP_READY = 1'b1;

    // rstn rv rw addr len wv wd | req_rdy wd_rdy busy pins addr idata
    add(0, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 0, P_IDLE, 16'h0000, 8'h00);
    add(0, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 0, P_IDLE, 16'h0000, 8'h00);
    add(0, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 0, P_IDLE, 16'h0000, 8'h00);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  1, 0, 0, P_IDLE, 16'h0000, 8'h00);
    add(1, 1, 1, 16'h1234, 0, 1, 8'hA5,  0, 1, 1, P_IDLE, 16'h0000, 8'h00);
    add(1, 0, 0, 16'h0000, 0, 1, 8'hA5,  0, 0, 1, P_WR,   16'h1234, 8'hA5);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h1234, 8'hA5);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h1234, 8'hA5);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  1, 0, 0, P_IDLE, 16'h1234, 8'hA5);
    // Two-beat write from 0x00FF with data arriving two cycles late on beat 0.
    add(1, 1, 1, 16'h00FF, 1, 0, 8'h00,  0, 1, 1, P_IDLE, 16'h1234, 8'hA5);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 1, 1, P_IDLE, 16'h1234, 8'hA5);
    add(1, 0, 0, 16'h0000, 0, 1, 8'h3C,  0, 0, 1, P_WR,   16'h00FF, 8'h3C);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h00FF, 8'h3C);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h00FF, 8'h3C);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 1, 1, P_IDLE, 16'h00FF, 8'h3C);
    add(1, 0, 0, 16'h0000, 0, 1, 8'hC3,  0, 0, 1, P_WR,   16'h0100, 8'hC3);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h0100, 8'hC3);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  0, 0, 1, P_IDLE, 16'h0100, 8'hC3);
    add(1, 0, 0, 16'h0000, 0, 0, 8'h00,  1, 0, 0, P_IDLE, 16'h0100, 8'hC3);

    for (int i = 0; i < vq.size(); i++) begin
      RSTN = vq[i].rstn; REQ_VALID = vq[i].rv; REQ_WRITE = vq[i].rw; REQ_ADDR = vq[i].ra;
      REQ_LEN = vq[i].rl; WD_VALID = vq[i].wv; WD_DATA = vq[i].wd;
      @(posedge CLK); #1;
      check($sformatf("vec%0d", i),
            {31'd0, REQ_READY, WD_READY, BUSY, CE, CSB, WEB, OEB, ADDR, IDATA, RSP_VALID},
            {31'd0, vq[i].er, vq[i].ewr, vq[i].eb, vq[i].epins, vq[i].ea, vq[i].ei, 1'b0});
    end
    REQ_VALID = 1'b0; WD_VALID = 1'b0;

    // Four-beat read from 0x0010 with RSP_READY tied high.
    exp_d[0] = 8'h4A; exp_d[1] = 8'h4B; exp_d[2] = 8'h48; exp_d[3] = 8'h49;
    iss_q.delete();
    do_req(1'b0, 16'h0010, 4'd3);
    wait_rsp(k);
    // Accept edge T, RSP_VALID in cycle T+4, i.e. after the third following edge.
    check("rd_first_latency", 64'(k), 64'd3);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        wait_rsp(k);
        check("rd_beat_period", 64'(k), 64'd6);
      end
      check($sformatf("rd_beat%0d_data_last", b), {55'd0, RSP_DATA, RSP_LAST},
            {55'd0, exp_d[b], (b == 3)});
    end
    wait_idle(k);
    check("rd_idle_after_last", 64'(k), 64'd3);
    check("rd_busy_cleared", 64'(BUSY), 64'd0);
    check("rd_issue_count", 64'(iss_q.size()), 64'd4);

    // Address wrap: 0xFFFF then 0x0000.
    iss_q.delete();
    do_req(1'b0, 16'hFFFF, 4'd1);
    wait_rsp(k);
    check("wrap_data0", {55'd0, RSP_DATA, RSP_LAST}, {55'd0, 8'hA5, 1'b0});
    wait_rsp(k);
    check("wrap_data1", {55'd0, RSP_DATA, RSP_LAST}, {55'd0, 8'h5A, 1'b1});
    wait_idle(k);
    a0 = 16'hxxxx; a1 = 16'hxxxx;
    if (iss_q.size() > 0) a0 = iss_q[0];
    if (iss_q.size() > 1) a1 = iss_q[1];
    check("wrap_issue_addr0", 64'(a0), 64'hFFFF);
    check("wrap_issue_addr1", 64'(a1), 64'h0000);

    // Backpressure on beat 0: response must hold and no second issue may occur.
    RSP_READY = 1'b0;
    iss_q.delete();
    do_req(1'b0, 16'h0040, 4'd1);
    wait_rsp(k);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      check($sformatf("bp_hold_c%0d", c), {54'd0, RSP_VALID, RSP_DATA, (iss_q.size() == 1)},
            {54'd0, 1'b1, 8'h1A, 1'b1});
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_clears_valid", 64'(RSP_VALID), 64'd0);
    wait_rsp(k);
    check("bp_beat1_data", {55'd0, RSP_DATA, RSP_LAST}, {55'd0, 8'h1B, 1'b1});
    wait_idle(k);

    // Reset during RD_WAIT of beat 1 of an eight-beat read.
    iss_q.delete();
    do_req(1'b0, 16'h0080, 4'd7);
    wait_rsp(k);
    check("rst_beat0_data", 64'(RSP_DATA), 64'hDA);
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (!CE && k < 20);
    check("rst_beat1_issue", {47'd0, CE, ADDR}, {47'd0, 1'b1, 16'h0081});
    @(posedge CLK); #1;
    check("rst_in_rd_wait", {61'd0, CE, CSB, OEB}, 64'b000);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid_flags", {56'd0, REQ_READY, BUSY, CE, CSB, WEB, OEB, RSP_VALID, RSP_LAST},
          {56'd0, 8'b0001_1100});
    check("rst_mid_data", {32'd0, ADDR, IDATA, RSP_DATA}, 64'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    check("rst_release_idle", {62'd0, REQ_READY, BUSY}, 64'b10);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (RSP_VALID || CE) stray++;
    end
    check("rst_no_stray_activity", 64'(stray), 64'd0);

    wr_q.delete();
    WD_VALID = 1'b1; WD_DATA = 8'h77;
    do_req(1'b1, 16'h2222, 4'd0);
    wait_idle(k);
    WD_VALID = 1'b0;
    w0 = 24'hxxxxxx;
    if (wr_q.size() > 0) w0 = wr_q[0];
    check("post_rst_write_count", 64'(wr_q.size()), 64'd1);
    check("post_rst_write_beat", 64'(w0), 64'h222277);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memctrl_host_master.md
# memctrl_host_master

Host-side initiator for the memory controller's external pin interface. It turns valid/ready read and write burst requests into per-beat CE/CSB/WEB/OEB/ADDR/IDATA pin sequences and captures ODATA into a backpressured response stream. It sits between a system bus or testbench driver and the memory controller top, and drives exactly the pins the controller samples.

## Interface
- RD_LAT, 2: cycles from the read issue cycle to the cycle in which ODATA is valid and sampled; legal range 1..7.
- GAP, 1: idle cycles (CSB=1, CE=0) inserted after every beat; legal range 0..3.

- CLK  in  1  single clock; all logic on the rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready; registered.
- REQ_WRITE  in  1  1 = write burst, 0 = read burst.
- REQ_ADDR  in  16  start address.
- REQ_LEN  in  4  number of beats minus 1 (1..16 beats).
- WD_VALID  in  1  write-data valid.
- WD_READY  out  1  write-data ready.
- WD_DATA  in  8  write data for the current beat.
- RSP_VALID  out  1  read response valid.
- RSP_READY  in  1  read response accepted.
- RSP_DATA  out  8  captured read data.
- RSP_LAST  out  1  marks the final beat of the burst.
- BUSY  out  1  high in every state except IDLE.
- ADDR  out  16  memory address pin.
- CE  out  1  chip enable pin, active-high.
- CSB  out  1  chip select pin, active-low.
- WEB  out  1  write enable pin, active-low.
- OEB  out  1  output enable pin, active-low.
- IDATA  out  8  memory write-data pin.
- ODATA  in  8  memory read-data pin.

## Operation
- All outputs are registered, except WD_READY, which is high exactly in WR_WAIT.
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_LAST=0, BUSY=0, ADDR=0, CE=0, CSB=1, WEB=1, OEB=1, IDATA=0, beat counter=0, latency counter=0.
- States: IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_HOLD, GAP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&&REQ_READY, latch REQ_ADDR, REQ_LEN and REQ_WRITE, and drop REQ_READY.
  - Go to WR_WAIT if write, RD_ISSUE if read.
- WR_WAIT:
  - Pins idle.
  - On WD_VALID, latch WD_DATA and go to WR_ISSUE.
- WR_ISSUE: exactly one cycle with CE=1, CSB=0, WEB=0, OEB=1, ADDR=current address, IDATA=latched data.
- RD_ISSUE: one cycle with CE=1, CSB=0, WEB=1, OEB=0, ADDR=current address.
- RD_WAIT:
  - CE=0; CSB=0, OEB=0 and ADDR are held.
  - The counter runs RD_LAT cycles. ODATA is sampled at the end of the last one into RSP_DATA.
  - RSP_VALID=1 and RSP_LAST=(beat==len) from the next cycle, when state goes to RD_HOLD with CSB=1, OEB=1.
- RD_HOLD: RSP_VALID is held stable until RSP_READY, then cleared on that edge and the FSM goes to GAP.
- GAP:
  - GAP idle cycles.
  - If the beat counter < len: increment the beat counter and the address, then go to WR_WAIT or RD_ISSUE.
  - Otherwise go to IDLE.
  - With GAP=0 the GAP state lasts exactly one decision cycle with pins idle.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000. The beat counter is 4-bit; a burst never exceeds REQ_LEN+1 beats.
- Idle pin value in any non-issue, non-wait state: CE=0, CSB=1, WEB=1, OEB=1; ADDR and IDATA hold their last values.
- Only one read is outstanding. No new read is issued while RSP_VALID=1.
- Reset mid-burst: the next edge with RSTN=0 forces all reset values. Remaining beats are dropped, and a pending response is discarded without handshake.

## Timing
- Request accepted at edge T → REQ_READY=0 from T+1.
- Write, WD_VALID already high at T+1: WR_ISSUE during cycle T+2. A late WD_VALID delays the issue cycle one-for-one.
- Read: issue in cycle T+1, ODATA sampled at the end of cycle T+1+RD_LAT, RSP_VALID from cycle T+2+RD_LAT.
- Write beat period with data always valid: 2+GAP+1 cycles (WR_WAIT, WR_ISSUE, GAP, decision).
- Read beat period with RSP_READY tied high: 1+RD_LAT+1+GAP+1 cycles.
- REQ_READY returns to 1 in the first cycle the FSM is in IDLE after the last beat's GAP.
- Simultaneous RSP_READY and final-beat completion: response consumed, IDLE reached after GAP, no extra beat.

## Test plan
- Reset, then idle: RSTN=0 for 3 cycles → CSB=1, CE=0, WEB=1, OEB=1, REQ_READY=0. The first cycle after release shows REQ_READY=1, BUSY=0.
- Single write: REQ_WRITE=1, ADDR=0x1234, LEN=0, WD_DATA=0xA5 held valid → one cycle of CE=1/CSB=0/WEB=0 with ADDR=0x1234, IDATA=0xA5. REQ_READY back to 1 after GAP.
- Read burst with a memory model of RD_LAT=2 returning ADDR[7:0]^0x5A: REQ_ADDR=0x0010, LEN=3 → RSP_DATA 0x4A, 0x4B, 0x48, 0x49, with RSP_LAST only on the 4th beat. The first RSP_VALID appears 4 cycles after acceptance.
- Wrap: read LEN=1 from 0xFFFF → issue addresses 0xFFFF then 0x0000.
- Backpressure: RSP_READY low for 5 cycles on beat 0 → RSP_VALID/RSP_DATA stable, no second RD_ISSUE until acceptance.
- Reset mid-burst: assert RSTN=0 during RD_WAIT of beat 1 of a LEN=7 read → next edge shows idle pins and RSP_VALID=0. After release, a new write completes normally.
